// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared definitions for the run controller: FSM state encoding and the
// MIPS syscall instruction encoding used by the optional syscall halt.
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,   // core held in reset
      RUN  = 2'd1,   // core executing
      DONE = 2'd2,   // program ended normally (terminal)
      TOUT = 2'd3    // watchdog expired (terminal)
   } state_t;

   localparam logic [31:0] SYSCALL_ENC = 32'h0000000C;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
// Ports:
//   i_clk  clock
//   i_clr  synchronous clear (dominates i_en)
//   i_en   count enable
//   o_cnt  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_cnt <= '0;
      else if (i_en && (r_cnt != {W{1'b1}}))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Run controller for the pipelined MIPS core: holds the core in reset for
// RST_CYCLES after system reset, then runs it while counting cycles and
// retirements, and stops it on a jump-to-self loop (HALT_REPEAT consecutive
// retirements at one PC) or when the watchdog (MAX_CYCLES, 0 = off) expires.
// Optional build macro RUN_CTRL_SYSCALL_HALT_EN: a retired syscall
// (ret_instr == 32'h0000000C) also ends the run.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ret_valid/pc/instr  retirement report from the writeback stage
//   cpu_reset           reset to the core
//   cpu_stall           freezes the core after the run ends
//   running/done/timeout  status (done/timeout sticky until reset)
//   cycle_cnt           RUN cycles, saturating
//   retire_cnt          retired instructions, saturating
// -----------------------------------------------------------------------------
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int RST_CYCLES  = 4,
   parameter int HALT_REPEAT = 3,
   parameter int MAX_CYCLES  = 100000,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ret_valid,
   input  logic [31:0]      ret_pc,
   input  logic [31:0]      ret_instr,
   output logic             cpu_reset,
   output logic             cpu_stall,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
   // same_cnt counts repeats after the first hit, so the final match
   // arrives while it holds HALT_REPEAT-2.
   localparam logic [3:0]       SAME_LAST = 4'(HALT_REPEAT - 2);
   localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_CYCLES - 1);

   state_t      r_state, w_next;
   logic [7:0]  r_hold_cnt;
   logic [3:0]  r_same_cnt;
   logic [31:0] r_last_pc;
   logic        r_last_vld;

   logic        r_cpu_reset, r_cpu_stall, r_running, r_done, r_timeout;

   logic [CNT_W-1:0] w_cycle_cnt, w_retire_cnt;
   logic        w_ret, w_match, w_loop_halt, w_sys_halt, w_wdog;

   assign w_ret       = (r_state == RUN) && ret_valid;
   assign w_match     = r_last_vld && (ret_pc == r_last_pc);
   assign w_loop_halt = w_ret && w_match && (r_same_cnt == SAME_LAST);
   assign w_wdog      = (MAX_CYCLES != 0) && (w_cycle_cnt == MAX_M1);

`ifdef RUN_CTRL_SYSCALL_HALT_EN
   assign w_sys_halt  = w_ret && (ret_instr == SYSCALL_ENC);
`else
   logic w_unused_instr;
   assign w_unused_instr = ^ret_instr;
   assign w_sys_halt     = 1'b0;
`endif

   // next state; a halt in the same cycle as the watchdog wins
   always_comb begin
      w_next = r_state;
      case (r_state)
         HOLD:    if (r_hold_cnt == HOLD_LAST) w_next = RUN;
         RUN: begin
            if (w_loop_halt || w_sys_halt) w_next = DONE;
            else if (w_wdog)               w_next = TOUT;
         end
         default: w_next = r_state;   // DONE/TOUT are terminal
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= HOLD;
         r_hold_cnt <= '0;
         r_same_cnt <= '0;
         r_last_pc  <= '0;
         r_last_vld <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == HOLD)
            r_hold_cnt <= r_hold_cnt + 8'd1;
         if (w_ret) begin
            if (w_match) begin
               r_same_cnt <= r_same_cnt + 4'd1;
            end else begin
               r_same_cnt <= '0;
               r_last_pc  <= ret_pc;
               r_last_vld <= 1'b1;
            end
         end
      end
   end

   // status outputs registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpu_reset <= 1'b1;
         r_cpu_stall <= 1'b0;
         r_running   <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_cpu_reset <= (w_next == HOLD);
         r_cpu_stall <= (w_next == DONE) || (w_next == TOUT);
         r_running   <= (w_next == RUN);
         r_done      <= (w_next == DONE);
         r_timeout   <= (w_next == TOUT);
      end
   end

   // counters only advance in RUN, so they freeze once the run ends
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .i_clk (clk),
      .i_clr (reset),
      .i_en  (r_state == RUN),
      .o_cnt (w_cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .i_clk (clk),
      .i_clr (reset),
      .i_en  (w_ret),
      .o_cnt (w_retire_cnt)
   );

   assign cpu_reset  = r_cpu_reset;
   assign cpu_stall  = r_cpu_stall;
   assign running    = r_running;
   assign done       = r_done;
   assign timeout    = r_timeout;
   assign cycle_cnt  = w_cycle_cnt;
   assign retire_cnt = w_retire_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
// Two instances share stimulus:
//   A: RST_CYCLES=4, HALT_REPEAT=3, MAX_CYCLES=10, CNT_W=32
//   B: RST_CYCLES=2, HALT_REPEAT=4, MAX_CYCLES=0 (no watchdog), CNT_W=4
// Every cycle both are compared with a behavioural model that tracks run
// length of identical retired PCs and elapsed release cycles.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, ret_valid = 1'b0;
   logic [31:0] ret_pc = '0, ret_instr = '0;

   logic        a_cr, a_st, a_run, a_dn, a_to;
   logic [31:0] a_cyc, a_ret;
   logic        b_cr, b_st, b_run, b_dn, b_to;
   logic [3:0]  b_cyc, b_ret;

   run_ctrl #(.RST_CYCLES(4), .HALT_REPEAT(3), .MAX_CYCLES(10), .CNT_W(32)) u_a (
      .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_instr(ret_instr), .cpu_reset(a_cr), .cpu_stall(a_st),
      .running(a_run), .done(a_dn), .timeout(a_to),
      .cycle_cnt(a_cyc), .retire_cnt(a_ret));

   run_ctrl #(.RST_CYCLES(2), .HALT_REPEAT(4), .MAX_CYCLES(0), .CNT_W(4)) u_b (
      .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_instr(ret_instr), .cpu_reset(b_cr), .cpu_stall(b_st),
      .running(b_run), .done(b_dn), .timeout(b_to),
      .cycle_cnt(b_cyc), .retire_cnt(b_ret));

   int checks = 0, errors = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_rstc[2] = '{4, 2};
   int          m_halt[2] = '{3, 4};
   int          m_max[2]  = '{10, 0};
   int unsigned m_cmax[2] = '{32'hFFFF_FFFF, 32'd15};

   int unsigned m_rel[2], m_cyc[2], m_ret[2];
   int          m_len[2];
   bit          m_run[2], m_done[2], m_tout[2], m_have[2];
   logic [31:0] m_last[2];

   function automatic void model_step(int d, bit rst, bit rv, logic [31:0] pc,
                                      logic [31:0] ins);
      bit halt, wd;
      halt = 0;
      if (rst) begin
         m_rel[d] = 0; m_cyc[d] = 0; m_ret[d] = 0; m_len[d] = 0;
         m_run[d] = 0; m_done[d] = 0; m_tout[d] = 0; m_have[d] = 0;
         m_last[d] = '0;
      end else if (m_done[d] || m_tout[d]) begin
         // terminal
      end else if (!m_run[d]) begin
         m_rel[d]++;
         if (m_rel[d] == m_rstc[d]) m_run[d] = 1;
      end else begin
         wd = (m_max[d] != 0) && (m_cyc[d] == m_max[d] - 1);
         if (m_cyc[d] != m_cmax[d]) m_cyc[d]++;
         if (rv) begin
            if (m_ret[d] != m_cmax[d]) m_ret[d]++;
            if (m_have[d] && pc == m_last[d]) m_len[d]++;
            else m_len[d] = 1;
            m_last[d] = pc;
            m_have[d] = 1;
            if (m_len[d] == m_halt[d]) halt = 1;
`ifdef RUN_CTRL_SYSCALL_HALT_EN
            if (ins == 32'h0000000C) halt = 1;
`endif
         end
         if (halt) begin
            m_done[d] = 1; m_run[d] = 0;
         end else if (wd) begin
            m_tout[d] = 1; m_run[d] = 0;
         end
      end
      if (ins == 32'h1) halt = 0;   // keeps ins referenced in every build
   endfunction

   task automatic cmp_models();
      chk("A.cpu_reset", a_cr,  m_run[0] || m_done[0] || m_tout[0] ? 0 : 1);
      chk("A.running",   a_run, m_run[0]);
      chk("A.done",      a_dn,  m_done[0]);
      chk("A.timeout",   a_to,  m_tout[0]);
      chk("A.cpu_stall", a_st,  m_done[0] || m_tout[0]);
      chk("A.cycle_cnt", a_cyc, m_cyc[0]);
      chk("A.retire_cnt",a_ret, m_ret[0]);
      chk("B.cpu_reset", b_cr,  m_run[1] || m_done[1] || m_tout[1] ? 0 : 1);
      chk("B.running",   b_run, m_run[1]);
      chk("B.done",      b_dn,  m_done[1]);
      chk("B.timeout",   b_to,  m_tout[1]);
      chk("B.cpu_stall", b_st,  m_done[1] || m_tout[1]);
      chk("B.cycle_cnt", {28'd0, b_cyc}, m_cyc[1]);
      chk("B.retire_cnt",{28'd0, b_ret}, m_ret[1]);
   endtask

   // drive one cycle, advance the model, compare #1 after the edge
   task automatic step(bit rst, bit rv, logic [31:0] pc, logic [31:0] ins);
      reset = rst; ret_valid = rv; ret_pc = pc; ret_instr = ins;
      @(posedge clk);
      model_step(0, rst, rv, pc, ins);
      model_step(1, rst, rv, pc, ins);
      #1;
      cmp_models();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0);
   endtask

   // ---------------- directed table for instance A ----------------
   typedef struct {
      bit          rst, rv;
      logic [31:0] pc;
      bit          cr, run, dn, st;
      int unsigned cyc, ret;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1, 0, 32'h0,    1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 32'h0,    1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 32'h3000, 1, 0, 0, 0, 0, 0};  // ignored in HOLD
      tbl[3]  = '{0, 0, 32'h0,    1, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 32'h0,    1, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 32'h0,    0, 1, 0, 0, 0, 0};  // 4th edge: RUN
      tbl[6]  = '{0, 1, 32'h3000, 0, 1, 0, 0, 1, 1};
      tbl[7]  = '{0, 1, 32'h3004, 0, 1, 0, 0, 2, 2};
      tbl[8]  = '{0, 1, 32'h3008, 0, 1, 0, 0, 3, 3};
      tbl[9]  = '{0, 1, 32'h3008, 0, 1, 0, 0, 4, 4};
      tbl[10] = '{0, 0, 32'h0,    0, 1, 0, 0, 5, 4};  // gap keeps the count
      tbl[11] = '{0, 1, 32'h3008, 0, 0, 1, 1, 6, 5};  // DONE
      tbl[12] = '{0, 1, 32'h3008, 0, 0, 1, 1, 6, 5};  // frozen
      tbl[13] = '{0, 0, 32'h0,    0, 0, 1, 1, 6, 5};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rst, tbl[i].rv, tbl[i].pc, 32'h0);
         chk($sformatf("tbl%0d.cpu_reset", i), a_cr,  tbl[i].cr);
         chk($sformatf("tbl%0d.running", i),   a_run, tbl[i].run);
         chk($sformatf("tbl%0d.done", i),      a_dn,  tbl[i].dn);
         chk($sformatf("tbl%0d.cpu_stall", i), a_st,  tbl[i].st);
         chk($sformatf("tbl%0d.cycle_cnt", i), a_cyc, tbl[i].cyc);
         chk($sformatf("tbl%0d.retire_cnt", i),a_ret, tbl[i].ret);
      end

      // different PC in between restarts the repeat count
      step(1, 0, 0, 0); idle(4);
      step(0, 1, 32'h3008, 0); step(0, 1, 32'h3008, 0);
      step(0, 1, 32'h300C, 0); step(0, 1, 32'h3008, 0);
      chk("restart.done", a_dn, 0);
      chk("restart.running", a_run, 1);

      // watchdog at MAX_CYCLES=10
      step(1, 0, 0, 0); idle(4); idle(9);
      chk("wdog.pre_timeout", a_to, 0);
      chk("wdog.pre_cyc", a_cyc, 9);
      idle(1);
      chk("wdog.timeout", a_to, 1);
      chk("wdog.done", a_dn, 0);
      chk("wdog.stall", a_st, 1);
      idle(2);
      chk("wdog.frozen_cyc", a_cyc, 10);

      // halt lands on the watchdog cycle: done wins
      step(1, 0, 0, 0); idle(4); idle(7);
      step(0, 1, 32'h3008, 0); step(0, 1, 32'h3008, 0); step(0, 1, 32'h3008, 0);
      chk("tie.done", a_dn, 1);
      chk("tie.timeout", a_to, 0);
      chk("tie.retire", a_ret, 3);

      // reset mid-RUN, then a full HOLD again
      step(1, 0, 0, 0); idle(4); idle(7);
      chk("midrst.cyc7", a_cyc, 7);
      step(1, 1, 32'h3008, 0);
      chk("midrst.cpu_reset", a_cr, 1);
      chk("midrst.running", a_run, 0);
      chk("midrst.cyc", a_cyc, 0);
      idle(3);
      chk("midrst.hold3", a_cr, 1);
      idle(1);
      chk("midrst.hold_end_cr", a_cr, 0);
      chk("midrst.hold_end_run", a_run, 1);

      // B: 4-bit counters saturate, watchdog disabled
      step(1, 0, 0, 0); idle(22);
      chk("B.sat_cyc", {28'd0, b_cyc}, 15);
      chk("B.no_timeout", b_to, 0);
      chk("B.still_running", b_run, 1);

      // syscall retirement
      step(1, 0, 0, 0); idle(4);
      step(0, 1, 32'h400, 32'h0000000C);
`ifdef RUN_CTRL_SYSCALL_HALT_EN
      chk("syscall.done", a_dn, 1);
      chk("syscall.retire", a_ret, 1);
`else
      chk("syscall.ignored_done", a_dn, 0);
      chk("syscall.ignored_run", a_run, 1);
`endif

      // randomized episodes against the model
      for (int ep = 0; ep < 60; ep++) begin
         int n;
         step(1, 0, 0, 0);
         n = $urandom_range(3, 30);
         for (int i = 0; i < n; i++) begin
            bit          r, v;
            logic [31:0] p, ins;
            r   = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 3) != 0);
            p   = 32'h100 + 32'($urandom_range(0, 2)) * 4;
            ins = ($urandom_range(0, 15) == 0) ? 32'h0000000C : $urandom;
            step(r, v, p, ins);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
